alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execute stage that sits directly upstream of the ALU output register.
- Accepts an opcode and two operands over a valid/ready handshake, computes the result, and presents outR/outCarry/outZero to the output register over a second valid/ready handshake.
- Single-cycle ops take one clock; multiply is an iterative shift-add of WIDTH clocks.
- Not pipelined: at most one operation is in flight.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk_in  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  the operation on opcode/a/b is valid.
- in_ready  out  1  the block accepts an operation this cycle.
- opcode  in  3  operation select (encodings in the package).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  outR/outCarry/outZero hold a finished result.
- out_ready  in  1  the downstream output register takes the result this cycle.
- outR  out  WIDTH  result.
- outCarry  out  1  carry, borrow or overflow flag.
- outZero  out  1  1 when outR == 0.
- busy  out  1  1 while in the MUL state.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; outR=0, outCarry=0, outZero=0, out_valid=0, busy=0. Any in-flight operation is discarded.
- States: IDLE, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). A new operation can therefore be accepted in the same cycle the previous result is consumed.
- Accept happens on a rising edge where in_valid && in_ready. On accept, opcode/a/b are sampled and their later changes are ignored.
- Ops, all in WIDTH-bit unsigned arithmetic:
  - ADD (000): {outCarry,outR} = a + b.
  - SUB (001): outR = a - b; outCarry = 1 when a < b (borrow).
  - AND (010), OR (011), XOR (100): bitwise; outCarry = 0.
  - SHL (101): outR = a << 1; outCarry = a[WIDTH-1].
  - SHR (110): outR = a >> 1; outCarry = a[0].
  - MUL (111): product P = a*b (2*WIDTH bits); outR = P[WIDTH-1:0]; outCarry = |P[2*WIDTH-1:WIDTH].
- Single-cycle op accepted at edge N: result registered at edge N; out_valid=1 from edge N onward; state=DONE.
- MUL accepted at edge N:
  - state=MUL and busy=1 after edge N.
  - Internal iteration counter runs 0..WIDTH-1, one partial product per edge (add multiplicand if multiplier LSB is 1, then shift).
  - On the edge completing iteration WIDTH-1 (edge N+WIDTH): outputs are loaded, state=DONE, busy=0, out_valid=1.
  - in_ready=0 throughout MUL.
- DONE: outputs are held stable while out_valid && !out_ready.
  - out_ready=1 with in_valid=0: state=IDLE, out_valid=0 at the next edge. outR and flags keep their last values.
  - out_ready=1 with in_valid=1: the new op is accepted at the same edge; behaviour is as from IDLE.
- outZero is always registered together with outR and is always consistent with it.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; no queuing.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ADD..OP_MUL.
  - State encodings ST_IDLE, ST_MUL, ST_DONE.
  - Shared with the output register and the bench.
- Sub-module alu_mul_seq: iterative shift-add multiplier with start/done.
  - Ports: clk_in, rst, start, a, b, done, prod[2*WIDTH-1:0].
  - alu_exec instantiates it and gates its start with the accept of OP_MUL.

Test Plan (WIDTH=8):
- Reset: hold rst low mid-MUL, release -> out_valid=0, outR=0, busy=0, in_ready=1 on the first cycle after release.
- ADD a=0xF0, b=0x20, out_ready=1 -> one cycle later out_valid=1, outR=0x10, outCarry=1, outZero=0.
- SUB a=0x05, b=0x05 -> outR=0x00, outCarry=0, outZero=1. Then SUB a=0x03, b=0x05 -> outR=0xFE, outCarry=1.
- MUL a=0x10, b=0x11 -> busy=1 for 8 cycles, in_ready=0 during them; then outR=0x10, outCarry=1. MUL a=0x0F, b=0x0F -> outR=0xE1, outCarry=0.
- Backpressure: XOR a=0xAA, b=0xFF with out_ready=0 for 5 cycles -> outR=0x55 held stable, in_ready=0; out_ready=1 with a pending SHL a=0x81 -> same-edge accept, next result outR=0x02, outCarry=1.
- Back-to-back: AND, OR, SHR issued every cycle with out_ready=1 -> one result per cycle, no drops or duplicates, verified against a reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: opcode encodings and FSM states.
// Used by alu_exec, the downstream output register and the testbench.
package alu_pkg;

    localparam int unsigned OPCODE_W = 3;

    // Opcode encodings presented on the opcode input.
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_OR  = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_SHL = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_SHR = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_MUL = 3'b111;

    // Execute-stage FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // True for opcodes that need the iterative multiplier.
    function automatic logic is_multicycle(input logic [OPCODE_W-1:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Handshake bundle between the issuing stage, the execute stage and the output register.
// slave: the execute stage; master: the side that issues ops and consumes results.
interface alu_exec_if #(
    parameter int unsigned WIDTH = 8
);
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    outR;
    logic                outCarry;
    logic                outZero;
    logic                busy;

    modport slave (
        input  in_valid,
        input  opcode,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output outR,
        output outCarry,
        output outZero,
        output busy
    );

    modport master (
        output in_valid,
        output opcode,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  outR,
        input  outCarry,
        input  outZero,
        input  busy
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier. Operands are captured on the start edge; one partial
// product is accumulated per following edge. done is high in the cycle before the edge
// that completes the last iteration, and prod then shows the final product, so the
// consumer can register the result on that same edge.
module alu_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CntW-1:0]    cnt_q;
    logic               run_q;

    // Next accumulator value: add the shifted multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    assign done = run_q && (cnt_q == LastIter);
    assign prod = acc_d;

    // Operand capture on start, then one shift-add step per edge until the last iteration.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CntW'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage. Takes one op at a time over a valid/ready handshake, computes
// single-cycle ops directly into the result registers and hands MUL to the iterative
// multiplier. The result is held until the output register takes it; a new op may be
// accepted on the same edge the previous result is consumed.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk_in,
    input logic          rst,
    alu_exec_if.slave    bus
);

    state_e           state_q;
    logic [WIDTH-1:0] out_r_q;
    logic             out_carry_q;
    logic             out_zero_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             in_ready;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             mul_carry;

    // Ready when idle, or when the held result is being taken this cycle.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign mul_start = accept && is_multicycle(bus.opcode);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.outR      = out_r_q;
    assign bus.outCarry  = out_carry_q;
    assign bus.outZero   = out_zero_q;
    assign bus.busy      = busy_q;

    // Single-cycle datapath on the live operands; only used on the accept edge.
    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        res_d   = '0;
        carry_d = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
            end
            OP_SUB: begin
                // The extra MSB of the widened difference is the borrow.
                res_d   = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];
            end
            OP_AND:  res_d = bus.a & bus.b;
            OP_OR:   res_d = bus.a | bus.b;
            OP_XOR:  res_d = bus.a ^ bus.b;
            OP_SHL: begin
                res_d   = {bus.a[WIDTH-2:0], 1'b0};
                carry_d = bus.a[WIDTH-1];
            end
            OP_SHR: begin
                res_d   = {1'b0, bus.a[WIDTH-1:1]};
                carry_d = bus.a[0];
            end
            default: begin
                res_d   = '0;
                carry_d = 1'b0;
            end
        endcase
    end

    // Overflow flag for MUL: any bit set in the upper half of the product.
    assign mul_carry = |mul_prod[2*WIDTH-1:WIDTH];

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul_seq (
        .clk_in (clk_in),
        .rst    (rst),
        .start  (mul_start),
        .a      (bus.a),
        .b      (bus.b),
        .done   (mul_done),
        .prod   (mul_prod)
    );

    // Control FSM with registered result, flags, out_valid and busy.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            out_r_q     <= '0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_multicycle(bus.opcode)) begin
                            state_q     <= ST_MUL;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_DONE;
                            out_r_q     <= res_d;
                            out_carry_q <= carry_d;
                            out_zero_q  <= (res_d == '0);
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == ST_DONE) && bus.out_ready) begin
                        // Result consumed with nothing new: keep outR/flags, drop valid.
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_r_q     <= mul_prod[WIDTH-1:0];
                        out_carry_q <= mul_carry;
                        out_zero_q  <= (mul_prod[WIDTH-1:0] == '0);
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec (WIDTH=8). Inputs change and outputs are sampled
// 1 time unit after the rising edge.
module tb_alu_exec;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests_run = 0;
    int   tests_failed = 0;

    alu_exec_if #(.WIDTH(8)) bus ();

    alu_exec #(
        .WIDTH (8)
    ) u_dut (
        .clk_in (clk),
        .rst    (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = av;
        bus.b        = bv;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.opcode = OP_ADD; bus.a = '0; bus.b = '0;
        tick(); tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.outR !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_hold: valid=%b busy=%b outR=%h want 0/0/00",
                     bus.out_valid, bus.busy, bus.outR);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(OP_ADD, 8'h01, 8'h02);
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.outR !== 8'h03 || bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_pre_add: outR=%h valid=%b want 03/1", bus.outR, bus.out_valid);
        end
        tick();
        drive(OP_MUL, 8'h10, 8'h11);
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        tests_run++;
        if (bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_mul_busy: busy=%b want 1", bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.outR !== 8'h00 ||
            bus.outCarry !== 1'b0 || bus.outZero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: busy=%b valid=%b outR=%h c=%b z=%b want 0/0/00/0/0",
                     bus.busy, bus.out_valid, bus.outR, bus.outCarry, bus.outZero);
        end
        tick();
        #3 rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.outR !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_release: rdy=%b valid=%b busy=%b outR=%h want 1/0/0/00",
                     bus.in_ready, bus.out_valid, bus.busy, bus.outR);
        end
        repeat (10) tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_discard: valid=%b busy=%b want 0/0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        drive(OP_ADD, 8'hF0, 8'h20);
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.outR !== 8'h10 || bus.outCarry !== 1'b1 ||
            bus.outZero !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_carry: valid=%b outR=%h c=%b z=%b want 1/10/1/0",
                     bus.out_valid, bus.outR, bus.outCarry, bus.outZero);
        end
        drive(OP_ADD, 8'hFF, 8'h01);
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.outR !== 8'h00 || bus.outCarry !== 1'b1 || bus.outZero !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_wrap: outR=%h c=%b z=%b want 00/1/1",
                     bus.outR, bus.outCarry, bus.outZero);
        end
        tick();
    endtask

    task automatic test_sub();
        bus.out_ready = 1'b1;
        drive(OP_SUB, 8'h05, 8'h05);
        tick();
        tests_run++;
        if (bus.outR !== 8'h00 || bus.outCarry !== 1'b0 || bus.outZero !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_equal: outR=%h c=%b z=%b want 00/0/1",
                     bus.outR, bus.outCarry, bus.outZero);
        end
        drive(OP_SUB, 8'h03, 8'h05);
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.outR !== 8'hFE || bus.outCarry !== 1'b1 || bus.outZero !== 1'b0 ||
            bus.out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_borrow: outR=%h c=%b z=%b valid=%b want FE/1/0/1",
                     bus.outR, bus.outCarry, bus.outZero, bus.out_valid);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.outR !== 8'hFE || bus.outCarry !== 1'b1) begin
            tests_failed++;
            $display("FAIL sub_drain_keep: valid=%b outR=%h c=%b want 0/FE/1",
                     bus.out_valid, bus.outR, bus.outCarry);
        end
    endtask

    task automatic test_mul();
        int busy_cycles;
        int ready_seen;
        bus.out_ready = 1'b1;
        drive(OP_MUL, 8'h10, 8'h11);
        tick();
        busy_cycles = 0;
        ready_seen  = 0;
        for (int i = 0; i < 8; i++) begin
            // Junk op and changed operands while busy must be ignored.
            drive(OP_ADD, 8'hFF, 8'hFF);
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.in_ready !== 1'b0) ready_seen++;
            tick();
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (busy_cycles != 8 || ready_seen != 0) begin
            tests_failed++;
            $display("FAIL mul_busy: busy_cycles=%0d ready_cycles=%0d want 8/0",
                     busy_cycles, ready_seen);
        end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.outR !== 8'h10 ||
            bus.outCarry !== 1'b1 || bus.outZero !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_ovf: valid=%b busy=%b outR=%h c=%b z=%b want 1/0/10/1/0",
                     bus.out_valid, bus.busy, bus.outR, bus.outCarry, bus.outZero);
        end
        tick();
        drive(OP_MUL, 8'h0F, 8'h0F);
        tick();
        bus.in_valid = 1'b0;
        repeat (7) tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mul_early: valid=%b busy=%b want 0/1", bus.out_valid, bus.busy);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.outR !== 8'hE1 || bus.outCarry !== 1'b0 ||
            bus.outZero !== 1'b0) begin
            tests_failed++;
            $display("FAIL mul_small: valid=%b outR=%h c=%b z=%b want 1/E1/0/0",
                     bus.out_valid, bus.outR, bus.outCarry, bus.outZero);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int bad;
        bus.out_ready = 1'b0;
        drive(OP_XOR, 8'hAA, 8'hFF);
        tick();
        // Pending SHL presented while the result is stalled.
        drive(OP_SHL, 8'h81, 8'h00);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.outR !== 8'h55 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_hold: %0d bad cycles, want outR=55 valid=1 rdy=0 for 5", bad);
        end
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_ready: in_ready=%b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.outR !== 8'h02 || bus.outCarry !== 1'b1 ||
            bus.outZero !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_same_edge_shl: valid=%b outR=%h c=%b z=%b want 1/02/1/0",
                     bus.out_valid, bus.outR, bus.outCarry, bus.outZero);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.outR !== 8'h02) begin
            tests_failed++;
            $display("FAIL bp_drain: valid=%b outR=%h want 0/02", bus.out_valid, bus.outR);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [6];
        logic [7:0] va  [6];
        logic [7:0] vb  [6];
        logic [7:0] er  [6];
        logic       ec  [6];
        logic       ez  [6];
        ops = '{OP_AND, OP_OR,  OP_SHR, OP_AND, OP_OR,  OP_SHR};
        va  = '{8'hF0,  8'h0F,  8'h81,  8'h55,  8'h00,  8'h02};
        vb  = '{8'h3C,  8'hA0,  8'hFF,  8'hAA,  8'h00,  8'h00};
        er  = '{8'h30,  8'hAF,  8'h40,  8'h00,  8'h00,  8'h01};
        ec  = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
        ez  = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], va[i], vb[i]);
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.outR !== er[i] || bus.outCarry !== ec[i] ||
                bus.outZero !== ez[i]) begin
                tests_failed++;
                $display("FAIL b2b_%0d: valid=%b outR=%h c=%b z=%b want 1/%h/%b/%b", i,
                         bus.out_valid, bus.outR, bus.outCarry, bus.outZero, er[i], ec[i], ez[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: valid=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
